// File: rtl/audio_pkg.sv
// Purpose: shared audio sample types and default I2S framing parameters.
// Contents: default widths/divider, per-channel sample type, stereo sample payload.
package audio_pkg;

   localparam int unsigned AUDIO_DATA_W  = 16;
   localparam int unsigned AUDIO_SLOT_W  = 32;
   localparam int unsigned AUDIO_SCK_DIV = 8;

   typedef logic signed [AUDIO_DATA_W-1:0] audio_sample_t;

   typedef struct packed {
      audio_sample_t l;
      audio_sample_t r;
   } stereo_sample_t;

endpackage

// File: rtl/i2s_bit_clock_gen.sv
// Purpose: derives MCLK (clk/2) and the I2S bit clock from the system clock,
//          and flags the divider terminal-count cycles that move SCLK.
// Ports:
//   clk_i      system clock
//   reset_i    synchronous active-high reset
//   mclk_o     master clock, toggles every clk cycle
//   sclk_o     bit clock, period 2*SCK_DIV clk cycles
//   rise_c_o   terminal count while SCLK is low (SCLK rises next edge)
//   fall_c_o   terminal count while SCLK is high (SCLK falls next edge)
module i2s_bit_clock_gen
   import audio_pkg::*;
#(
   parameter int unsigned SCK_DIV = AUDIO_SCK_DIV
) (
   input  logic clk_i,
   input  logic reset_i,
   output logic mclk_o,
   output logic sclk_o,
   output logic rise_c_o,
   output logic fall_c_o
);

   localparam int unsigned DIV_W    = (SCK_DIV > 1) ? $clog2(SCK_DIV) : 1;
   localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(SCK_DIV - 1);

   logic [DIV_W-1:0] div_cnt_q, div_cnt_d;
   logic             sck_q, sck_d;
   logic             mclk_q, mclk_d;
   logic             tc;

   // Divider and clock toggles
   always_comb begin
      tc        = (div_cnt_q == DIV_LAST);
      div_cnt_d = tc ? '0 : div_cnt_q + DIV_W'(1);
      sck_d     = tc ? ~sck_q : sck_q;
      mclk_d    = ~mclk_q;
   end

   always_ff @(posedge clk_i) begin
      if (reset_i) begin
         div_cnt_q <= '0;
         sck_q     <= 1'b0;
         mclk_q    <= 1'b0;
      end else begin
         div_cnt_q <= div_cnt_d;
         sck_q     <= sck_d;
         mclk_q    <= mclk_d;
      end
   end

   assign mclk_o   = mclk_q;
   assign sclk_o   = sck_q;
   assign rise_c_o = tc & ~sck_q;
   assign fall_c_o = tc & sck_q;

endmodule

// File: rtl/i2s_dac_tx.sv
// Purpose: I2S transmitter for the board audio codec. Latches one stereo
//          sample per frame and shifts it out MSB first with the standard
//          one-SCLK delay after each LRCK edge.
// Ports:
//   clk_chipset    system clock, all logic on its rising edge
//   reset          synchronous active-high reset
//   l_data/r_data  channel samples, sampled only on the latch cycle
//   mute           loads zeros instead of the samples at the latch cycle
//   sample_strobe  high during the cycle the samples are latched
//   dac_MCLK       clk_chipset/2
//   dac_SCLK       bit clock
//   dac_LRCK       word clock, 0 = left slot, 1 = right slot
//   dac_SDIN       serial data, changes with SCLK falling
module i2s_dac_tx
   import audio_pkg::*;
#(
   parameter int unsigned DATA_W    = AUDIO_DATA_W,
   parameter int unsigned SLOT_W    = AUDIO_SLOT_W,
   parameter int unsigned SCK_DIV   = AUDIO_SCK_DIV,
   parameter bit          SIGNED_IN = 1'b1
) (
   input  logic              clk_chipset,
   input  logic              reset,
   input  logic [DATA_W-1:0] l_data,
   input  logic [DATA_W-1:0] r_data,
   input  logic              mute,
   output logic              sample_strobe,
   output logic              dac_MCLK,
   output logic              dac_SCLK,
   output logic              dac_LRCK,
   output logic              dac_SDIN
);

   localparam int unsigned FRAME_W = 2 * SLOT_W;
   localparam int unsigned CNT_W   = $clog2(FRAME_W);
   localparam int unsigned IDX_W   = (DATA_W > 1) ? $clog2(DATA_W) : 1;
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(FRAME_W - 1);
   localparam logic [CNT_W-1:0] CNT_SLOT = CNT_W'(SLOT_W);
   localparam logic [CNT_W-1:0] CNT_DATA = CNT_W'(DATA_W);

   if (SCK_DIV < 2) begin : g_chk_div
      $error("i2s_dac_tx: SCK_DIV must be >= 2");
   end
   if (DATA_W > SLOT_W - 1) begin : g_chk_width
      $error("i2s_dac_tx: DATA_W must be <= SLOT_W-1");
   end

   // Offset-binary inputs become two's complement by flipping the MSB
   function automatic logic [DATA_W-1:0] conv(input logic [DATA_W-1:0] s);
      conv = s;
      if (!SIGNED_IN) conv[DATA_W-1] = ~s[DATA_W-1];
   endfunction

   logic [CNT_W-1:0]  bit_cnt_q, bit_cnt_d;
   logic              lrck_q, lrck_d;
   logic              sdin_q, sdin_d;
   logic [DATA_W-1:0] shadow_l_q, shadow_l_d;
   logic [DATA_W-1:0] shadow_r_q, shadow_r_d;
   logic [CNT_W-1:0]  slot_pos;
   logic [IDX_W-1:0]  bit_idx;
   logic              frame_start_c;
   logic              fall_c;
   logic              unused_rise_c;

   i2s_bit_clock_gen #(
      .SCK_DIV (SCK_DIV)
   ) u_bit_clock_gen (
      .clk_i    (clk_chipset),
      .reset_i  (reset),
      .mclk_o   (dac_MCLK),
      .sclk_o   (dac_SCLK),
      .rise_c_o (unused_rise_c),
      .fall_c_o (fall_c)
   );

   // Frame sequencing: every update is on the SCLK-fall cycle
   always_comb begin
      bit_cnt_d     = bit_cnt_q;
      lrck_d        = lrck_q;
      sdin_d        = sdin_q;
      shadow_l_d    = shadow_l_q;
      shadow_r_d    = shadow_r_q;
      slot_pos      = '0;
      bit_idx       = '0;
      frame_start_c = fall_c & (bit_cnt_q == CNT_LAST);

      if (fall_c) begin
         bit_cnt_d = frame_start_c ? '0 : bit_cnt_q + CNT_W'(1);
         lrck_d    = (bit_cnt_d >= CNT_SLOT);
         slot_pos  = lrck_d ? bit_cnt_d - CNT_SLOT : bit_cnt_d;
         bit_idx   = IDX_W'(DATA_W - 32'(slot_pos));
         // Position 0 of a slot still carries padding (one-SCLK I2S delay)
         if ((slot_pos != '0) && (slot_pos <= CNT_DATA)) begin
            sdin_d = lrck_d ? shadow_r_q[bit_idx] : shadow_l_q[bit_idx];
         end else begin
            sdin_d = 1'b0;
         end
         if (frame_start_c) begin
            shadow_l_d = mute ? '0 : conv(l_data);
            shadow_r_d = mute ? '0 : conv(r_data);
         end
      end
   end

   always_ff @(posedge clk_chipset) begin
      if (reset) begin
         bit_cnt_q  <= CNT_LAST;
         lrck_q     <= 1'b0;
         sdin_q     <= 1'b0;
         shadow_l_q <= '0;
         shadow_r_q <= '0;
      end else begin
         bit_cnt_q  <= bit_cnt_d;
         lrck_q     <= lrck_d;
         sdin_q     <= sdin_d;
         shadow_l_q <= shadow_l_d;
         shadow_r_q <= shadow_r_d;
      end
   end

   assign sample_strobe = frame_start_c & ~reset;
   assign dac_LRCK      = lrck_q;
   assign dac_SDIN      = sdin_q;

endmodule

// File: tb/tb_i2s_dac_tx.sv
// Bench for i2s_dac_tx: a default (signed) instance driven by directed
// stimulus, plus an offset-binary instance fed 0000/FFFF.
module tb_i2s_dac_tx;
   import audio_pkg::*;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic        reset;
   logic [15:0] l_drv, r_drv;
   logic        mute_drv;
   logic        strobe, mclk, sclk, lrck, sdin;
   logic        u_strobe, u_mclk, u_sclk, u_lrck, u_sdin;

   i2s_dac_tx dut (
      .clk_chipset(clk), .reset(reset), .l_data(l_drv), .r_data(r_drv),
      .mute(mute_drv), .sample_strobe(strobe), .dac_MCLK(mclk),
      .dac_SCLK(sclk), .dac_LRCK(lrck), .dac_SDIN(sdin)
   );

   i2s_dac_tx #(.SIGNED_IN(1'b0)) dut_u (
      .clk_chipset(clk), .reset(reset), .l_data(16'h0000), .r_data(16'hFFFF),
      .mute(1'b0), .sample_strobe(u_strobe), .dac_MCLK(u_mclk),
      .dac_SCLK(u_sclk), .dac_LRCK(u_lrck), .dac_SDIN(u_sdin)
   );

   int total = 0;
   int bad   = 0;
   int cyc;

   // cyc == n during the n-th cycle after reset release
   always @(posedge clk) begin
      if (reset) cyc <= 0;
      else       cyc <= cyc + 1;
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Scoreboard: expected words pushed at each strobe from the driven stimulus
   typedef struct {
      logic        ch;
      logic [15:0] w;
   } word_t;
   word_t exp_q[$];

   always @(negedge clk) begin
      if (strobe === 1'b1) begin
         exp_q.push_back('{1'b0, mute_drv ? 16'h0000 : l_drv});
         exp_q.push_back('{1'b1, mute_drv ? 16'h0000 : r_drv});
      end
   end

   int words0 = 0;
   int words1 = 0;
   int pad_bad = 0;

   task automatic word_done(input int inst, input logic ch, input logic [15:0] w);
      word_t e;
      if (inst == 1) begin
         words1++;
         check(ch ? "u_right_word" : "u_left_word", {16'h0, w}, ch ? 32'h7FFF : 32'h8000);
      end else begin
         words0++;
         if (exp_q.size() == 0) begin
            total++;
            bad++;
            $error("FAIL sb_word observed=%0h expected=none", {ch, w});
         end else begin
            e = exp_q.pop_front();
            check("sb_word", {15'h0, ch, w}, {15'h0, e.ch, e.w});
         end
      end
   endtask

   // Receiver: samples SDIN on SCLK rises, slot position restarts on LRCK change
   logic [1:0]  sclk_v, lrck_v, sdin_v;
   logic [1:0]  sclk_p, lrck_p;
   int          pos [2];
   logic [15:0] sh  [2];
   assign sclk_v = {u_sclk, sclk};
   assign lrck_v = {u_lrck, lrck};
   assign sdin_v = {u_sdin, sdin};

   always @(negedge clk) begin
      for (int i = 0; i < 2; i++) begin
         if (reset) begin
            pos[i]    = -2;
            lrck_p[i] = 1'b0;
         end else if (sclk_v[i] && !sclk_p[i]) begin
            if (lrck_v[i] != lrck_p[i]) pos[i] = 0;
            else                        pos[i] = pos[i] + 1;
            lrck_p[i] = lrck_v[i];
            if (pos[i] >= 1 && pos[i] <= 16) begin
               sh[i] = {sh[i][14:0], sdin_v[i]};
               if (pos[i] == 16) word_done(i, lrck_v[i], sh[i]);
            end else if (sdin_v[i] !== 1'b0) begin
               pad_bad++;
            end
         end
         sclk_p[i] = sclk_v[i];
      end
   end

   // Edge-timing monitor on the default instance
   logic sdin_p0, sclk_p0, lrck_p0, mclk_p0;
   int   sdin_bad = 0, sdin_chg = 0;
   bit   meas_en = 1'b0;
   int   t_sclk, t_lrck, t_mclk, t_strb;
   int   n_sclk, n_lrck, n_mclk, n_strb;
   int   b_sclk, b_lrck, b_mclk, b_strb;

   always @(negedge clk) begin
      if (!reset && sdin !== sdin_p0) begin
         sdin_chg++;
         if (!(sclk_p0 === 1'b1 && sclk === 1'b0)) sdin_bad++;
      end
      if (meas_en) begin
         if (sclk && !sclk_p0) begin
            if (t_sclk >= 0 && cyc - t_sclk != 16) b_sclk++;
            t_sclk = cyc; n_sclk++;
         end
         if (lrck && !lrck_p0) begin
            if (t_lrck >= 0 && cyc - t_lrck != 1024) b_lrck++;
            t_lrck = cyc; n_lrck++;
         end
         if (mclk && !mclk_p0) begin
            if (t_mclk >= 0 && cyc - t_mclk != 2) b_mclk++;
            t_mclk = cyc; n_mclk++;
         end
         if (strobe) begin
            if (t_strb >= 0 && cyc - t_strb != 1024) b_strb++;
            t_strb = cyc; n_strb++;
         end
      end
      sdin_p0 = sdin; sclk_p0 = sclk; lrck_p0 = lrck; mclk_p0 = mclk;
   end

   task automatic wait_strobe(input string tag, output int at);
      at = -1;
      for (int i = 0; i < 1100 && at < 0; i++) begin
         @(negedge clk);
         if (strobe === 1'b1) at = cyc;
      end
      if (at < 0) begin
         total++;
         bad++;
         $error("FAIL %s observed=timeout expected=strobe", tag);
      end
   endtask

   task automatic check_zero(input string tag);
      check(tag, {22'h0, strobe, mclk, sclk, lrck, sdin,
                  u_strobe, u_mclk, u_sclk, u_lrck, u_sdin}, 32'h0);
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog observed=running expected=finished");
      $fatal(1, "watchdog");
   end

   initial begin
      int at;
      int lr_at;
      reset    = 1'b1;
      l_drv    = 16'hA5C3;
      r_drv    = 16'h3C5A;
      mute_drv = 1'b0;

      // Reset state
      repeat (4) @(posedge clk);
      @(negedge clk);
      check_zero("reset_outputs");
      @(posedge clk); #1 reset = 1'b0;

      // First frame timing after release
      wait_strobe("first_strobe", at);
      check("first_strobe_cycle", at, 15);
      lr_at = -1;
      for (int i = 0; i < 700 && lr_at < 0; i++) begin
         @(negedge clk);
         if (lrck === 1'b1) lr_at = cyc;
      end
      check("lrck_first_high_cycle", lr_at, 528);

      // Periods over four frames
      wait_strobe("period_align", at);
      repeat (100) @(negedge clk);
      t_sclk = -1; t_lrck = -1; t_mclk = -1; t_strb = -1;
      n_sclk = 0;  n_lrck = 0;  n_mclk = 0;  n_strb = 0;
      b_sclk = 0;  b_lrck = 0;  b_mclk = 0;  b_strb = 0;
      meas_en = 1'b1;
      repeat (4096) @(negedge clk);
      meas_en = 1'b0;
      check("sclk_period_errs", b_sclk, 0);
      check("sclk_rise_count_ok", 32'(n_sclk >= 250), 1);
      check("lrck_period_errs", b_lrck, 0);
      check("lrck_rise_count", n_lrck, 4);
      check("mclk_period_errs", b_mclk, 0);
      check("mclk_rise_count_ok", 32'(n_mclk >= 2000), 1);
      check("strobe_period_errs", b_strb, 0);
      check("strobe_count", n_strb, 4);

      // Inputs toggling every cycle
      @(posedge clk);
      for (int i = 0; i < 2100; i++) begin
         #1;
         l_drv = i[0] ? 16'h7FFF : 16'h8000;
         r_drv = i[0] ? 16'h8000 : 16'h7FFF;
         @(posedge clk);
      end
      #1;
      l_drv = 16'h1234;
      r_drv = 16'h1234;

      // Mute applied and removed mid-frame
      wait_strobe("mute_pre", at);
      wait_strobe("mute_frame0", at);
      repeat (300) @(posedge clk);
      #1 mute_drv = 1'b1;
      wait_strobe("mute_frame1", at);
      repeat (300) @(posedge clk);
      #1 mute_drv = 1'b0;
      wait_strobe("mute_frame2", at);
      wait_strobe("mute_frame3", at);

      // Reset for 3 cycles while bit_cnt = 40
      repeat (645) @(posedge clk);
      #1 reset = 1'b1;
      @(posedge clk);
      @(negedge clk);
      check_zero("midreset_outputs_1");
      exp_q.delete();
      @(posedge clk);
      @(negedge clk);
      check_zero("midreset_outputs_2");
      @(posedge clk); #1 reset = 1'b0;
      wait_strobe("post_reset_strobe", at);
      check("post_reset_strobe_cycle", at, 15);
      wait_strobe("drain", at);
      repeat (20) @(negedge clk);

      check("padding_bits_nonzero", pad_bad, 0);
      check("sdin_change_off_fall", sdin_bad, 0);
      check("sdin_activity_ok", 32'(sdin_chg >= 100), 1);
      check("signed_words_ok", 32'(words0 >= 24), 1);
      check("unsigned_words_ok", 32'(words1 >= 24), 1);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
